// File: rtl/iic_slave_regs.sv
// I2C slave that exposes an 8-bit register pointer and a byte write/read port.
// It handles auto-increment, repeated START, and an open-drain SDA pull-down.
module iic_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1001100
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_oe,
  output logic [7:0] Reg_addr,
  output logic [7:0] Wr_data,
  output logic       Wr_stb,
  input  logic [7:0] Rd_data,
  output logic       Busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       ack_phase;
  logic       rw;

  logic       scl_rise, scl_fall, start_det, stop_det, last_bit;
  logic [7:0] byte_in;

  // The synchronizers idle at 1 so a released bus never looks like a START.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop takes its neighbour's pre-edge value; blocking would collapse the chain.
      scl_s1 <= SCL_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= SDA_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign last_bit  = (bit_cnt == 3'd7);
  assign byte_in   = {shift[6:0], sda_s2};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      SDA_oe    <= 1'b0;
      Reg_addr  <= 8'h00;
      Wr_data   <= 8'h00;
      Wr_stb    <= 1'b0;
      Busy      <= 1'b0;
      shift     <= 8'h00;
      bit_cnt   <= 3'd0;
      ack_phase <= 1'b0;
      rw        <= 1'b0;
    end else begin
      Wr_stb <= 1'b0;
      // The pointer advances the cycle after every write strobe, even if the bus is already moving on.
      if (Wr_stb) Reg_addr <= Reg_addr + 8'd1;

      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        ack_phase <= 1'b0;
        SDA_oe    <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        ack_phase <= 1'b0;
        SDA_oe    <= 1'b0;
        Busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: SDA_oe <= 1'b0;

          ADDR: if (scl_rise) begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              if (shift[6:0] == SLAVE_ADDR) begin
                state <= ADDR_ACK;
                rw    <= sda_s2;
                Busy  <= 1'b1;
              end else begin
                state <= IDLE;
                Busy  <= 1'b0;
              end
            end
          end

          // First fall after bit 8 pulls SDA low; the next fall releases it and moves on.
          ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              SDA_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              SDA_oe    <= 1'b0;
              ack_phase <= 1'b0;
              bit_cnt   <= 3'd0;
              if (state == ADDR_ACK) begin
                if (rw) begin
                  state  <= RDATA;
                  shift  <= Rd_data;
                  SDA_oe <= ~Rd_data[7];
                end else begin
                  state <= REG;
                end
              end else if (state == REG_ACK) begin
                Reg_addr <= shift;
                state    <= WDATA;
              end else begin
                state <= WDATA;
              end
            end
          end

          REG: if (scl_rise) begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) state <= REG_ACK;
          end

          WDATA: if (scl_rise) begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              Wr_data <= byte_in;
              Wr_stb  <= 1'b1;
              state   <= WDATA_ACK;
            end
          end

          RDATA: begin
            if (scl_fall) SDA_oe <= ~shift[7];
            if (scl_rise) begin
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) state <= RDATA_ACK;
            end
          end

          // ack_phase marks a received master ACK; the pointer moves first so the reload sees the next register.
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                state <= IDLE;
                Busy  <= 1'b0;
              end else begin
                Reg_addr  <= Reg_addr + 8'd1;
                ack_phase <= 1'b1;
              end
            end else if (scl_fall) begin
              if (ack_phase) begin
                shift     <= Rd_data;
                SDA_oe    <= ~Rd_data[7];
                bit_cnt   <= 3'd0;
                ack_phase <= 1'b0;
                state     <= RDATA;
              end else begin
                SDA_oe <= 1'b0;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_slave_regs.sv
// Bench for iic_slave_regs: a bit-banged I2C master plus a transaction-level model
// of the register file and pointer, with directed scenarios and a randomized mix.
`timescale 1ns/1ps
module tb_iic_slave_regs;

  localparam logic [6:0] SLV = 7'b1001100;
  localparam int Q = 60;  // quarter SCL period in ns (SCL = 24 Clk periods)

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       msda = 1'b1;
  logic       sda_line;
  logic       SDA_oe, Wr_stb, Busy;
  logic [7:0] Reg_addr, Wr_data, Rd_data;

  logic [7:0] mem [256];        // external register file driven by the DUT strobes
  logic [7:0] model_mem [256];  // what the bus transactions say the registers hold
  logic [7:0] ptr;              // model register pointer
  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];
  logic [15:0] exp_q [$];
  logic       quiet = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  assign sda_line = msda & ~SDA_oe;
  assign Rd_data  = mem[Reg_addr];

  always @(posedge Clk) if (Wr_stb) mem[Reg_addr] <= Wr_data;

  iic_slave_regs #(.SLAVE_ADDR(SLV)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .SCL_in(scl), .SDA_in(sda_line),
    .SDA_oe(SDA_oe), .Reg_addr(Reg_addr), .Wr_data(Wr_data),
    .Wr_stb(Wr_stb), .Rd_data(Rd_data), .Busy(Busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare: every strobe must match the next expected write, be one Clk wide,
  // and be followed one Clk later by the incremented pointer; unaddressed traffic stays silent.
  logic        prev_stb = 1'b0;
  logic        chk_inc = 1'b0;
  logic [7:0]  inc_addr;
  logic [15:0] exp_e;
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (chk_inc) begin
        check("addr_inc_after_stb", Reg_addr, inc_addr);
        chk_inc = 1'b0;
      end
      if (Wr_stb) begin
        check("stb_one_cycle", prev_stb, 0);
        check("stb_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          check("stb_addr", Reg_addr, exp_e[15:8]);
          check("stb_data", Wr_data, exp_e[7:0]);
          inc_addr = exp_e[15:8] + 8'd1;
          chk_inc  = 1'b1;
        end
      end
      if (quiet) begin
        check("quiet_sda_oe", SDA_oe, 0);
        check("quiet_busy", Busy, 0);
      end
    end
    prev_stb = Wr_stb;
  end

  task automatic clk_bit(input logic b, output logic s);
    msda = b; #(Q);
    scl = 1'b1; #(Q);
    s = sda_line; #(Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic bus_start;
    msda = 1'b1; #(Q);
    scl = 1'b1; #(Q);
    msda = 1'b0; #(Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic bus_stop;
    msda = 1'b0; #(Q);
    scl = 1'b1; #(Q);
    msda = 1'b1; #(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(nack, s);
  endtask

  // Write n bytes from wbuf starting at reg_a; optionally cut the next byte after abort_bits bits.
  task automatic do_write(input logic [6:0] dev, input logic [7:0] reg_a, input int n, input int abort_bits);
    logic ack, s, match;
    match = (dev == SLV);
    quiet = !match;
    bus_start;
    send_byte({dev, 1'b0}, ack);
    check("addr_ack", ack, !match);
    check("busy_after_addr", Busy, match);
    send_byte(reg_a, ack);
    check("reg_ack", ack, !match);
    if (match) ptr = reg_a;
    for (int i = 0; i < n; i++) begin
      if (match) exp_q.push_back({ptr, wbuf[i]});
      send_byte(wbuf[i], ack);
      check("data_ack", ack, !match);
      if (match) begin
        model_mem[ptr] = wbuf[i];
        ptr = ptr + 8'd1;
      end
    end
    for (int i = 0; i < abort_bits; i++) clk_bit(wbuf[n][7-i], s);
    bus_stop;
    #(4*Q);
    quiet = 1'b0;
    check("busy_after_stop", Busy, 0);
    check("sda_oe_idle", SDA_oe, 0);
    check("ptr_after_write", Reg_addr, ptr);
    check("all_stb_seen", exp_q.size(), 0);
  endtask

  // Read n bytes (last one NACKed), optionally setting the pointer first via a repeated START.
  task automatic do_read(input logic set_ptr, input logic [7:0] reg_a, input int n);
    logic ack;
    logic [7:0] b;
    quiet = 1'b0;
    bus_start;
    if (set_ptr) begin
      send_byte({SLV, 1'b0}, ack);
      check("rd_waddr_ack", ack, 0);
      send_byte(reg_a, ack);
      check("rd_reg_ack", ack, 0);
      ptr = reg_a;
      bus_start;
    end
    send_byte({SLV, 1'b1}, ack);
    check("rd_addr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      rbuf[i] = b;
      check("rd_byte", b, model_mem[ptr]);
      if (i < n - 1) ptr = ptr + 8'd1;
    end
    #(2*Q);
    check("busy_after_nack", Busy, 0);
    check("sda_oe_after_nack", SDA_oe, 0);
    bus_stop;
    #(4*Q);
    check("ptr_after_read", Reg_addr, ptr);
  endtask

  initial begin
    #(5ms);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack, s;
    int kind, n;
    logic [6:0] dev;

    for (int i = 0; i < 256; i++) begin
      mem[i]       = 8'(i + 8'h40);
      model_mem[i] = 8'(i + 8'h40);
    end
    ptr = 8'h00;

    #23;
    check("rst_sda_oe", SDA_oe, 0);
    check("rst_wr_stb", Wr_stb, 0);
    check("rst_busy", Busy, 0);
    check("rst_reg_addr", Reg_addr, 8'h00);
    check("rst_wr_data", Wr_data, 8'h00);
    @(negedge Clk) Reset_n = 1'b1;
    #(4*Q);

    // Single register write
    wbuf[0] = 8'hA4;
    do_write(SLV, 8'h1E, 1, 0);
    check("lit_reg_addr_1f", Reg_addr, 8'h1F);
    check("lit_mem_1e", mem[8'h1E], 8'hA4);

    // Foreign device address: bus must be left alone
    wbuf[0] = 8'hC0;
    do_write(7'h76, 8'h49, 1, 0);
    check("lit_mem_49_untouched", mem[8'h49], 8'h89);

    // Pointer wrap across 0xFF
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(SLV, 8'hFE, 3, 0);
    check("lit_mem_fe", mem[8'hFE], 8'h11);
    check("lit_mem_ff", mem[8'hFF], 8'h22);
    check("lit_mem_00", mem[8'h00], 8'h33);
    check("lit_reg_addr_01", Reg_addr, 8'h01);

    // Pointer set, repeated START, two-byte read
    do_read(1'b1, 8'h05, 2);
    check("lit_rd0", rbuf[0], 8'h45);
    check("lit_rd1", rbuf[1], 8'h46);
    check("lit_reg_addr_06", Reg_addr, 8'h06);

    // STOP four bits into a data byte, then a normal write
    wbuf[0] = 8'h5A; wbuf[1] = 8'hF0;
    do_write(SLV, 8'h70, 1, 4);
    check("lit_reg_addr_71", Reg_addr, 8'h71);
    wbuf[0] = 8'h3C;
    do_write(SLV, 8'h80, 1, 0);
    check("lit_mem_80", mem[8'h80], 8'h3C);

    // Reset pulse while the slave is pulling SDA low during a read (reg 0x20 holds 0x60, MSB 0)
    bus_start;
    send_byte({SLV, 1'b0}, ack);
    send_byte(8'h20, ack);
    bus_start;
    send_byte({SLV, 1'b1}, ack);
    check("pre_reset_ack", ack, 0);
    check("pre_reset_oe", SDA_oe, !model_mem[8'h20][7]);
    @(negedge Clk) Reset_n = 1'b0;
    #1;
    check("async_reset_oe", SDA_oe, 0);
    check("async_reset_busy", Busy, 0);
    check("async_reset_reg_addr", Reg_addr, 8'h00);
    @(negedge Clk) Reset_n = 1'b1;
    ptr = 8'h00;
    quiet = 1'b1;
    for (int i = 0; i < 9; i++) clk_bit(1'b1, s);
    bus_stop;
    #(4*Q);
    quiet = 1'b0;
    check("post_reset_reg_addr", Reg_addr, 8'h00);
    wbuf[0] = 8'h9D;
    do_write(SLV, 8'h33, 1, 0);
    check("lit_mem_33", mem[8'h33], 8'h9D);

    // Randomized mix of writes, reads, aborts and foreign addresses
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      n    = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
      case (kind)
        0: do_write(SLV, 8'($urandom), n, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
        1: do_read(1'b1, 8'($urandom), n);
        2: begin
          dev = 7'($urandom);
          if (dev == SLV) dev = dev ^ 7'h01;
          do_write(dev, 8'($urandom), n, 0);
        end
        default: do_read(1'b0, 8'h00, n);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iic_slave_regs.md
IIC_SLAVE_REGS -- requirements
Module: iic_slave_regs

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b1001100, the 7-bit device address the block responds to.
REQ-002 SHALL have port Clk  input  1  system clock; Clk frequency is at least 20x the SCL frequency.
REQ-003 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port SCL_in  input  1  bus clock from the master, asynchronous to Clk.
REQ-005 SHALL have port SDA_in  input  1  bus data as seen on the pad, asynchronous to Clk.
REQ-006 SHALL have port SDA_oe  output  1  1 = pull SDA low; 0 = release SDA (open drain).
REQ-007 SHALL have port Reg_addr  output  8  register pointer; also serves as the read address.
REQ-008 SHALL have port Wr_data  output  8  received data byte.
REQ-009 SHALL have port Wr_stb  output  1  one-Clk write strobe qualifying Reg_addr and Wr_data.
REQ-010 SHALL have port Rd_data  input  8  register contents at Reg_addr; sampled by the block, never latched externally.
REQ-011 SHALL have port Busy  output  1  high from an address-matched START until STOP, NACK or mismatch.

Function
REQ-012 SHALL pass SCL_in and SDA_in through 2-flop synchronizers each, then derive one-Clk rise and fall pulses from the synchronized SCL.
REQ-013 SHALL detect START when synchronized SDA falls while SCL is high, and STOP when SDA rises while SCL is high; START/STOP detection has priority over bit sampling in the same cycle.
REQ-014 SHALL sample SDA on each SCL rise pulse and change SDA_oe only on SCL fall pulses.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-016 SHALL go from any state to ADDR on START (covers repeated START) and from any state to IDLE on STOP; bit counter clears in both cases; Reg_addr is kept.
REQ-017 In ADDR, SHALL shift 8 bits MSB first; on the 8th bit, matching upper 7 bits go to ADDR_ACK, while a mismatch goes to IDLE with SDA_oe 0 until the next START.
REQ-018 In an ACK state, SHALL assert SDA_oe at the SCL fall after bit 8 and release it at the following SCL fall.
REQ-019 After ADDR_ACK, SHALL go to REG when R/W=0, or to RDATA when R/W=1, loading the shift register from Rd_data at the SCL fall that ends the ACK.
REQ-020 After REG_ACK, the REG byte SHALL load Reg_addr; the state then goes to WDATA.
REQ-021 On the 8th SCL rise of each WDATA byte, SHALL latch Wr_data and pulse Wr_stb for exactly one Clk with the current Reg_addr, then go to WDATA_ACK.
REQ-022 Reg_addr SHALL increment one Clk after each Wr_stb, wrapping 8'hFF to 8'h00.
REQ-023 After WDATA_ACK, SHALL return to WDATA for the next byte.
REQ-024 In RDATA, SHALL set SDA_oe = ~shift[7] at each SCL fall and shift at each SCL rise.
REQ-025 After 8 bits in RDATA, SHALL release SDA and go to RDATA_ACK, where it samples the master's bit at the SCL rise.
REQ-026 In RDATA_ACK, master ACK (0) SHALL increment Reg_addr (with wrap) and reload the shift register from Rd_data at the next SCL fall, then return to RDATA.
REQ-027 In RDATA_ACK, master NACK (1) SHALL send the state to IDLE with Busy low.
REQ-028 SHALL leave Wr_stb 0 and SDA_oe 0 in IDLE.
REQ-029 SHALL not fire Wr_stb for any byte cut short by START or STOP.

Reset
REQ-030 When Reset_n is low, SHALL immediately set SDA_oe=0, Wr_stb=0, Busy=0, Reg_addr=8'h00, Wr_data=8'h00, state=IDLE, bit counter=0, synchronizers=1.
REQ-031 After Reset_n deasserts, SHALL ignore the bus until the first START, including when reset occurs mid-transaction.

Verification
REQ-032 Bus write 0x98,0x1E,0xA4,STOP -> three ACKs; one Wr_stb with Reg_addr=0x1E and Wr_data=0xA4; Reg_addr=0x1F afterward; Busy low after STOP.
REQ-033 Bus write to address 0x76 (byte 0xEC), then 0x49,0xC0 -> SDA_oe never asserted; no Wr_stb; Busy stays 0.
REQ-034 Bus write 0x98,0xFE,0x11,0x22,0x33 -> Wr_stb at 0xFE, 0xFF, 0x00 with data 0x11, 0x22, 0x33 in order.
REQ-035 Bus write 0x98,0x05, repeated START, 0x99, read 2 bytes (ACK then NACK), with Rd_data model reg[n]=n+0x40 -> SDA carries 0x45 then 0x46; Reg_addr=0x06 at the end; Busy low after NACK.
REQ-036 STOP after 4 bits of a WDATA byte -> no Wr_stb; state IDLE; a following full write succeeds normally.
REQ-037 Reset_n low for 1 Clk during a READ with SDA_oe=1 -> SDA_oe=0 asynchronously; no further activity until the next START.
